ahb2apb_bridge: RTL and testbench
=================================

Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB3 master bridge. Terminates AHB transfers in the hclk domain and replays each one as an APB SETUP/ACCESS sequence.
- APB outputs change only on hclk edges where the divider's pclken strobe is high, so the APB side runs at the divided pclk rate.
- Sits between the AHB interconnect and the APB peripheral segment. Single APB slave select; address decode is downstream.

Parameters:
ADDR_WID, 32, AHB/APB address width
DATA_WID, 32, data bus width; only 32 is supported

Ports:
hclk  input  1  system clock
hresetn  input  1  reset: asynchronous, active-low
pclken  input  1  one-hclk-cycle strobe marking the hclk edge coincident with a pclk rising edge
hsel  input  1  AHB slave select
haddr  input  ADDR_WID  AHB address
htrans  input  2  AHB transfer type
hwrite  input  1  AHB write=1 / read=0
hsize  input  3  AHB size; ignored, always treated as word
hwdata  input  DATA_WID  AHB write data (data phase)
hready_in  input  1  AHB bus-level HREADY
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR
hrdata  output  DATA_WID  read data
paddr  output  ADDR_WID  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WID  APB write data
prdata  input  DATA_WID  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Clock hclk. Reset hresetn is asynchronous, active-low.
- Reset values: hreadyout=1; hresp, psel, penable and pwrite=0; paddr, pwdata and hrdata=0; FSM=IDLE.
- Valid address phase: hsel & htrans[1] & hready_in. It is sampled only when hreadyout=1, i.e. in IDLE or ERR2.
- On a valid address phase: latch haddr and hwrite; go to PEND.
- htrans IDLE/BUSY, or hsel=0: no action. Zero-wait OKAY response.
- FSM states: IDLE, PEND, SETUP, ACCESS, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0.
- PEND: hreadyout=0. hwdata is captured into a holding register on the first PEND cycle only.
  - On the first hclk edge with pclken=1: psel=1, penable=0, paddr and pwrite from the latch, pwdata from the holding register; go to SETUP.
  - That edge may be the first PEND edge; capture and launch then happen together.
- SETUP: on the next pclken edge, set penable=1; go to ACCESS.
- ACCESS: pready and pslverr are sampled only on pclken edges. pready=0 holds ACCESS.
  - On pready=1: psel=0 and penable=0; on reads, prdata is latched into hrdata.
  - pslverr=0: go to IDLE, giving hreadyout=1 and OKAY in the next cycle.
  - pslverr=1: go to ERR1.
- ERR1: hreadyout=0, hresp=1. Lasts one cycle, then ERR2.
- ERR2: hreadyout=1, hresp=1. Lasts one cycle. A valid address phase here is accepted (go to PEND), otherwise go to IDLE.
- Back-to-back transfers: the completion cycle (IDLE, hreadyout=1) accepts the next address phase with no dead cycle.
- Output hold rules:
  - paddr, pwrite and pwdata hold after psel falls.
  - hrdata holds until the next read completes. Write transfers do not modify it.
- Minimum latency with pclken tied to 1: 4 hclk data-phase cycles (PEND, SETUP, ACCESS, completion). The longer the pclken period, the more PEND/SETUP/ACCESS cycles.
- pclken stuck at 0: the bridge waits indefinitely with hreadyout=0. No timeout.
- pready and pslverr are ignored on hclk edges without pclken. pslverr is ignored when pready=0.
- Reset mid-transfer: immediate return to IDLE. psel and penable drop asynchronously; the pending transfer is discarded.

Test Plan:
- pclken=1 every cycle; write haddr=0x40, hwdata=0xDEADBEEF; pready=1 -> psel in data cycle 2, penable in cycle 3, paddr=0x40, pwdata=0xDEADBEEF, hreadyout=1 in cycle 4, hresp=0.
- pclken every 4th cycle; read 0x10 with pready low for 2 pclken edges, prdata=0x12345678 -> psel/penable change only on pclken edges, ACCESS spans 3 pclken edges, hrdata=0x12345678.
- Read with pready=1, pslverr=1 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE with hresp=0.
- Back-to-back write 0x0 then read 0x4, second address held during the first data phase -> second SETUP starts on the first pclken after completion; no extra idle cycle on AHB.
- htrans=IDLE and BUSY with hsel=1, and NONSEQ with hsel=0 -> psel never asserts, hreadyout stays 1, hresp=0.
- hresetn pulsed low during ACCESS -> psel=0, penable=0 and hreadyout=1 immediately; a following transfer completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle between the AHB-Lite interconnect / APB segment and the bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface ahb2apb_bridge_if #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
);
    // Divider strobe marking pclk rising edges in the hclk domain
    logic                pclken;
    // AHB-Lite side
    logic                hsel;
    logic [ADDR_WID-1:0] haddr;
    logic [1:0]          htrans;
    logic                hwrite;
    logic [2:0]          hsize;
    logic [DATA_WID-1:0] hwdata;
    logic                hready_in;
    logic                hreadyout;
    logic                hresp;
    logic [DATA_WID-1:0] hrdata;
    // APB3 side
    logic [ADDR_WID-1:0] paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_WID-1:0] pwdata;
    logic [DATA_WID-1:0] prdata;
    logic                pready;
    logic                pslverr;

    modport slave (
        input  pclken, hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
               prdata, pready, pslverr,
        output hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
    );

    modport master (
        output pclken, hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
               prdata, pready, pslverr,
        input  hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge. Each accepted AHB transfer is held
// off (hreadyout=0) while it is replayed as an APB SETUP/ACCESS sequence
// whose outputs only move on hclk edges qualified by pclken.
// Only a 32-bit data bus is supported; hsize is ignored (word access).
module ahb2apb_bridge #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
) (
    input  logic             hclk,
    input  logic             hresetn,
    ahb2apb_bridge_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_WID-1:0] wdata_q, wdata_d;
    logic                first_q, first_d;
    logic [ADDR_WID-1:0] paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_WID-1:0] pwdata_q, pwdata_d;
    logic [DATA_WID-1:0] hrdata_q, hrdata_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q, hresp_d;
    logic                addr_valid;

    // hsize and the SEQ/NONSEQ distinction carry no information for this bridge
    logic unused_inputs;
    assign unused_inputs = ^{bus.hsize, bus.htrans[0]};

    assign addr_valid = bus.hsel & bus.htrans[1] & bus.hready_in;

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        first_d   = 1'b0;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;

        case (state_q)
            // hreadyout is high only here, so these are the only states
            // that may accept an address phase
            S_IDLE, S_ERR2: begin
                if (addr_valid) begin
                    addr_d  = bus.haddr;
                    write_d = bus.hwrite;
                    first_d = 1'b1;
                    state_d = S_PEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PEND: begin
                // hwdata is only valid in the first data-phase cycle
                if (first_q) begin
                    wdata_d = bus.hwdata;
                end
                if (bus.pclken) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = addr_q;
                    pwrite_d  = write_q;
                    // capture and launch may coincide on the first PEND edge
                    pwdata_d  = first_q ? bus.hwdata : wdata_q;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (bus.pclken) begin
                    penable_d = 1'b1;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.pclken && bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!write_q) begin
                        hrdata_d = bus.prdata;
                    end
                    state_d = bus.pslverr ? S_ERR1 : S_IDLE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // AHB response flags are registered from the state being entered
        hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    end

    // State and output registers; reset drops the APB strobes immediately
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            first_q     <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            first_q     <= first_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.paddr     = paddr_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed testbench for ahb2apb_bridge: each task drives one scenario and
// compares outputs sampled 1 ns after the rising hclk edge.
module tb_ahb2apb_bridge;
    logic hclk;
    logic hresetn;
    int   n_checks;
    int   n_fail;

    ahb2apb_bridge_if #(.ADDR_WID(32), .DATA_WID(32)) bus ();

    ahb2apb_bridge #(.ADDR_WID(32), .DATA_WID(32)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        tick(); tick();
        n_checks++; if (bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout: got %b expected 1", bus.hreadyout); end
        n_checks++; if (bus.hresp !== 1'b0) begin n_fail++; $display("FAIL rst_hresp: got %b expected 0", bus.hresp); end
        n_checks++; if (bus.psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %b expected 0", bus.psel); end
        n_checks++; if (bus.penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b expected 0", bus.penable); end
        n_checks++; if (bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b expected 0", bus.pwrite); end
        n_checks++; if (bus.paddr !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h expected 0", bus.paddr); end
        n_checks++; if (bus.pwdata !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h expected 0", bus.pwdata); end
        n_checks++; if (bus.hrdata !== 32'h0) begin n_fail++; $display("FAIL rst_hrdata: got %h expected 0", bus.hrdata); end
        hresetn = 1'b1;
        tick();
        $display("txn reset released");
    endtask

    task automatic test_write_basic();
        bus.pclken = 1'b1; bus.pready = 1'b1; bus.pslverr = 1'b0;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h40; bus.hwrite = 1'b1;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'hDEADBEEF;
        n_checks++; if (bus.hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_c1_hreadyout: got %b expected 0", bus.hreadyout); end
        n_checks++; if (bus.psel !== 1'b0) begin n_fail++; $display("FAIL wr_c1_psel: got %b expected 0", bus.psel); end
        tick();
        bus.hwdata = 32'h0;
        n_checks++; if (bus.psel !== 1'b1) begin n_fail++; $display("FAIL wr_c2_psel: got %b expected 1", bus.psel); end
        n_checks++; if (bus.penable !== 1'b0) begin n_fail++; $display("FAIL wr_c2_penable: got %b expected 0", bus.penable); end
        n_checks++; if (bus.paddr !== 32'h40) begin n_fail++; $display("FAIL wr_c2_paddr: got %h expected 00000040", bus.paddr); end
        n_checks++; if (bus.pwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_c2_pwdata: got %h expected deadbeef", bus.pwdata); end
        n_checks++; if (bus.pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_c2_pwrite: got %b expected 1", bus.pwrite); end
        tick();
        n_checks++; if (bus.penable !== 1'b1 || bus.psel !== 1'b1) begin n_fail++; $display("FAIL wr_c3_access: got psel=%b penable=%b expected 1 1", bus.psel, bus.penable); end
        n_checks++; if (bus.hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_c3_hreadyout: got %b expected 0", bus.hreadyout); end
        tick();
        n_checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin n_fail++; $display("FAIL wr_c4_idle: got psel=%b penable=%b expected 0 0", bus.psel, bus.penable); end
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin n_fail++; $display("FAIL wr_c4_resp: got hreadyout=%b hresp=%b expected 1 0", bus.hreadyout, bus.hresp); end
        n_checks++; if (bus.pwdata !== 32'hDEADBEEF || bus.paddr !== 32'h40) begin n_fail++; $display("FAIL wr_c4_hold: got paddr=%h pwdata=%h expected 00000040 deadbeef", bus.paddr, bus.pwdata); end
        $display("txn write addr=0x40 data=0xdeadbeef pclken=1");
    endtask

    task automatic test_read_slow();
        logic pe;
        logic prev_psel;
        logic prev_pen;
        logic done;
        int   acc_edges;
        int   cycles;
        bus.pclken = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h12345678;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h10; bus.hwrite = 1'b0;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        prev_psel = bus.psel; prev_pen = bus.penable;
        acc_edges = 0; cycles = 0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            pe = ((k % 4) == 3);
            bus.pclken = pe;
            if (pe && bus.penable === 1'b1) acc_edges++;
            // pready/pslverr toggle on unqualified edges and must be ignored there
            bus.pready  = (acc_edges >= 3) || !pe;
            bus.pslverr = !pe || (acc_edges < 3);
            tick();
            cycles++;
            n_checks++;
            if (!pe && (bus.psel !== prev_psel || bus.penable !== prev_pen)) begin
                n_fail++;
                $display("FAIL rd_apb_off_strobe: got psel=%b penable=%b expected %b %b (cycle %0d)", bus.psel, bus.penable, prev_psel, prev_pen, cycles);
            end
            prev_psel = bus.psel; prev_pen = bus.penable;
            if (bus.hreadyout === 1'b1) done = 1'b1;
        end
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rd_timeout: got no completion expected completion"); end
        n_checks++; if (cycles != 20) begin n_fail++; $display("FAIL rd_latency: got %0d cycles expected 20", cycles); end
        n_checks++; if (acc_edges != 3) begin n_fail++; $display("FAIL rd_access_edges: got %0d expected 3", acc_edges); end
        n_checks++; if (bus.hrdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_hrdata: got %h expected 12345678", bus.hrdata); end
        n_checks++; if (bus.hresp !== 1'b0) begin n_fail++; $display("FAIL rd_hresp: got %b expected 0", bus.hresp); end
        n_checks++; if (bus.paddr !== 32'h10 || bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL rd_paddr: got paddr=%h pwrite=%b expected 00000010 0", bus.paddr, bus.pwrite); end
        $display("txn read addr=0x10 data=0x%h pclken=1/4 cycles=%0d", bus.hrdata, cycles);
    endtask

    task automatic test_error();
        bus.pclken = 1'b1; bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hBAD0BAD0;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h20; bus.hwrite = 1'b0;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        tick(); tick();
        n_checks++; if (bus.penable !== 1'b1) begin n_fail++; $display("FAIL err_access: got penable=%b expected 1", bus.penable); end
        tick();
        n_checks++; if (bus.hreadyout !== 1'b0 || bus.hresp !== 1'b1) begin n_fail++; $display("FAIL err_err1: got hreadyout=%b hresp=%b expected 0 1", bus.hreadyout, bus.hresp); end
        n_checks++; if (bus.psel !== 1'b0) begin n_fail++; $display("FAIL err_psel: got %b expected 0", bus.psel); end
        tick();
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1) begin n_fail++; $display("FAIL err_err2: got hreadyout=%b hresp=%b expected 1 1", bus.hreadyout, bus.hresp); end
        tick();
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin n_fail++; $display("FAIL err_idle: got hreadyout=%b hresp=%b expected 1 0", bus.hreadyout, bus.hresp); end
        n_checks++; if (bus.hrdata !== 32'hBAD0BAD0) begin n_fail++; $display("FAIL err_hrdata: got %h expected bad0bad0", bus.hrdata); end
        bus.pslverr = 1'b0;
        $display("txn read addr=0x20 slverr -> ERROR response");
    endtask

    task automatic test_back_to_back();
        bus.pclken = 1'b1; bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'h0BADF00D;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0; bus.hwrite = 1'b1;
        tick();
        bus.haddr = 32'h4; bus.hwrite = 1'b0; bus.hwdata = 32'hA5A5A5A5;
        n_checks++; if (bus.hreadyout !== 1'b0) begin n_fail++; $display("FAIL b2b_c1_hreadyout: got %b expected 0", bus.hreadyout); end
        tick();
        bus.hwdata = 32'h11111111;
        n_checks++; if (bus.psel !== 1'b1 || bus.paddr !== 32'h0 || bus.pwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_c2_setup: got psel=%b paddr=%h pwrite=%b expected 1 00000000 1", bus.psel, bus.paddr, bus.pwrite); end
        n_checks++; if (bus.pwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_c2_pwdata: got %h expected a5a5a5a5", bus.pwdata); end
        tick();
        tick();
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.psel !== 1'b0) begin n_fail++; $display("FAIL b2b_c4_done: got hreadyout=%b psel=%b expected 1 0", bus.hreadyout, bus.psel); end
        n_checks++; if (bus.hrdata !== 32'hBAD0BAD0) begin n_fail++; $display("FAIL b2b_wr_hrdata_hold: got %h expected bad0bad0", bus.hrdata); end
        $display("txn write addr=0x0 data=0xa5a5a5a5 (back-to-back 1/2)");
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        n_checks++; if (bus.hreadyout !== 1'b0) begin n_fail++; $display("FAIL b2b_c5_accept: got hreadyout=%b expected 0", bus.hreadyout); end
        tick();
        n_checks++; if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 32'h4 || bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_c6_setup: got psel=%b penable=%b paddr=%h pwrite=%b expected 1 0 00000004 0", bus.psel, bus.penable, bus.paddr, bus.pwrite); end
        tick();
        n_checks++; if (bus.penable !== 1'b1) begin n_fail++; $display("FAIL b2b_c7_access: got %b expected 1", bus.penable); end
        tick();
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.hrdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_c8_read: got hreadyout=%b hrdata=%h expected 1 0badf00d", bus.hreadyout, bus.hrdata); end
        $display("txn read addr=0x4 data=0x%h (back-to-back 2/2)", bus.hrdata);
    endtask

    task automatic test_no_action();
        logic       hs_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] ht_tab [3] = '{2'b00, 2'b01, 2'b10};
        bus.pclken = 1'b1; bus.pready = 1'b1; bus.haddr = 32'h50; bus.hwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.hsel = hs_tab[i]; bus.htrans = ht_tab[i];
            for (int c = 0; c < 3; c++) begin
                tick();
                n_checks++; if (bus.psel !== 1'b0 || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin n_fail++; $display("FAIL noact_%0d: got psel=%b hreadyout=%b hresp=%b expected 0 1 0", i, bus.psel, bus.hreadyout, bus.hresp); end
            end
            $display("txn ignored hsel=%b htrans=%b", hs_tab[i], ht_tab[i]);
        end
        bus.hsel = 1'b0; bus.htrans = 2'b00;
    endtask

    task automatic test_reset_mid();
        bus.pclken = 1'b1; bus.pready = 1'b0; bus.pslverr = 1'b0;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h80; bus.hwrite = 1'b1;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'hCAFEF00D;
        tick(); tick();
        n_checks++; if (bus.penable !== 1'b1) begin n_fail++; $display("FAIL rstmid_access: got penable=%b expected 1", bus.penable); end
        #2 hresetn = 1'b0;
        #1;
        n_checks++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL rstmid_async: got psel=%b penable=%b hreadyout=%b expected 0 0 1", bus.psel, bus.penable, bus.hreadyout); end
        #3 hresetn = 1'b1;
        bus.pready = 1'b1;
        tick();
        n_checks++; if (bus.psel !== 1'b0 || bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL rstmid_discard: got psel=%b hreadyout=%b expected 0 1", bus.psel, bus.hreadyout); end
        $display("txn write addr=0x80 aborted by reset");
        bus.prdata = 32'h600DCAFE;
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h84; bus.hwrite = 1'b0;
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        tick();
        n_checks++; if (bus.psel !== 1'b1 || bus.paddr !== 32'h84) begin n_fail++; $display("FAIL rstmid_setup: got psel=%b paddr=%h expected 1 00000084", bus.psel, bus.paddr); end
        tick(); tick();
        n_checks++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.hrdata !== 32'h600DCAFE) begin n_fail++; $display("FAIL rstmid_read: got hreadyout=%b hresp=%b hrdata=%h expected 1 0 600dcafe", bus.hreadyout, bus.hresp, bus.hrdata); end
        $display("txn read addr=0x84 data=0x%h after reset", bus.hrdata);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hresetn       = 1'b0;
        bus.pclken    = 1'b0;
        bus.hsel      = 1'b0;
        bus.haddr     = 32'h0;
        bus.htrans    = 2'b00;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'b010;
        bus.hwdata    = 32'h0;
        bus.hready_in = 1'b1;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        test_reset();
        test_write_basic();
        test_read_slow();
        test_error();
        test_back_to_back();
        test_no_action();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
